// File: rtl/timestamp_capture_pkg.sv
// Shared widths and the record layout for the timestamp capture block.
package timestamp_capture_pkg;

  localparam int TS_W   = 64;
  localparam int SEQ_W  = 16;
  localparam int CH_W   = 3;
  localparam int DROP_W = 16;
  localparam int REC_W  = CH_W + SEQ_W + TS_W;

  // Record as stored in the FIFO: channel in the MSBs, timestamp in the LSBs.
  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [SEQ_W-1:0] seq;
    logic [TS_W-1:0]  t;
  } rec_t;

  function automatic rec_t rec_pack(input logic [CH_W-1:0]  ch,
                                    input logic [SEQ_W-1:0] seq,
                                    input logic [TS_W-1:0]  ts);
    rec_t r;
    r.ch  = ch;
    r.seq = seq;
    r.t   = ts;
    return r;
  endfunction

endpackage

// File: rtl/timestamp_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of 2.
// A push while full is accepted only when a pop happens in the same cycle.
module timestamp_capture_fifo #(
  parameter int WIDTH = 83,
  parameter int DEPTH = 8
) (
  input  logic                     clk125,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == (AW+1)'(DEPTH));
  assign level     = r_cnt;
  assign dout      = r_mem[r_rd];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array; contents are meaningless while empty, so no reset
  always_ff @(posedge clk125) begin
    if (w_do_push) r_mem[r_wr] <= din;
  end

endmodule

// File: rtl/timestamp_capture.sv
// Captures the usec timestamp on qualified rising edges of async trigger
// pins and queues {channel, seq, timestamp} records for a valid/ready reader.
module timestamp_capture
  import timestamp_capture_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int MIN_PULSE  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk125,
  input  logic                          rst,
  input  logic [TS_W-1:0]               t,
  input  logic [N_CH-1:0]               trig,
  input  logic [N_CH-1:0]               trig_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_ch,
  output logic [SEQ_W-1:0]              out_seq,
  output logic [TS_W-1:0]               out_t,
  output logic [DROP_W-1:0]             drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // Down-counter only needs to hold MIN_PULSE-1.
  localparam int CNT_W = (MIN_PULSE < 2) ? 1 : $clog2(MIN_PULSE);

  logic [N_CH-1:0]   r_sync1;
  logic [N_CH-1:0]   r_sync2;
  logic [N_CH-1:0]   r_s_d;
  logic [N_CH-1:0]   r_active;
  logic [CNT_W-1:0]  r_left   [N_CH];
  logic [TS_W-1:0]   r_hold_t [N_CH];
  logic [N_CH-1:0]   r_pend;
  logic [TS_W-1:0]   r_pend_t [N_CH];
  logic [SEQ_W-1:0]  r_seq;
  logic [DROP_W-1:0] r_drop;

  logic [N_CH-1:0]   w_edge;
  logic [N_CH-1:0]   w_qual;
  logic [TS_W-1:0]   w_cap_t  [N_CH];
  logic [N_CH-1:0]   w_win_oh;
  logic [CH_W-1:0]   w_win_ch;
  logic [TS_W-1:0]   w_win_t;
  logic              w_any_pend;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [3:0]        w_drop_n;
  logic [DROP_W:0]   w_drop_sum;
  rec_t              w_din;
  rec_t              w_dout;

  // Two-flop synchronizer plus a delayed copy of the synced level for edge detect
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_s_d   <= '0;
    end else begin
      r_sync1 <= trig;
      r_sync2 <= r_sync1;
      r_s_d   <= r_sync2;
    end
  end

  // Edge detection keeps running while disabled so re-enable needs a fresh 0->1
  assign w_edge = r_sync2 & ~r_s_d & trig_en;

  // Pulse-width filter: arm at the edge, count down while the level stays high
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_active <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_left[i]   <= '0;
        r_hold_t[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!trig_en[i] || !r_sync2[i]) begin
          r_active[i] <= 1'b0;
        end else if (w_edge[i]) begin
          r_hold_t[i] <= t;
          r_active[i] <= 1'(MIN_PULSE > 1);
          r_left[i]   <= CNT_W'(MIN_PULSE - 1);
        end else if (r_active[i]) begin
          if (r_left[i] == CNT_W'(1)) r_active[i] <= 1'b0;
          else                        r_left[i]   <= r_left[i] - CNT_W'(1);
        end
      end
    end
  end

  // Qualification strobe and the edge timestamp that travels with it
  always_comb begin
    w_qual = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_cap_t[i] = (MIN_PULSE == 1) ? t : r_hold_t[i];
      if (MIN_PULSE == 1) w_qual[i] = w_edge[i];
      else w_qual[i] = trig_en[i] & r_sync2[i] & r_active[i] & (r_left[i] == CNT_W'(1));
    end
  end

  // Fixed-priority arbiter: lowest pending channel wins the single push slot
  always_comb begin
    w_win_oh = '0;
    w_win_ch = '0;
    w_win_t  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
        w_win_ch    = CH_W'(i);
        w_win_t     = r_pend_t[i];
      end
    end
  end

  assign w_any_pend = |r_pend;
  assign w_pop      = ~w_empty & out_ready;
  assign w_push     = w_any_pend & (~w_full | w_pop);
  assign w_din      = rec_pack(w_win_ch, r_seq, w_win_t);

  // Pending slot per channel; a qualification that finds the slot busy is dropped
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < N_CH; i++) r_pend_t[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (!trig_en[i]) begin
          r_pend[i] <= 1'b0;
        end else if (w_qual[i] && !r_pend[i]) begin
          r_pend[i]   <= 1'b1;
          r_pend_t[i] <= w_cap_t[i];
        end else if (w_push && w_win_oh[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // Number of channels dropping an event this cycle, added with saturation
  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_drop_n = w_drop_n + {3'b000, w_qual[i] & r_pend[i]};
    end
    w_drop_sum = {1'b0, r_drop} + (DROP_W+1)'(w_drop_n);
  end

  // Sequence number advances only on an actual push; drop counter saturates
  always_ff @(posedge clk125) begin
    if (rst) begin
      r_seq  <= '0;
      r_drop <= '0;
    end else begin
      if (w_push) r_seq <= r_seq + SEQ_W'(1);
      if (w_drop_sum[DROP_W]) r_drop <= '1;
      else                    r_drop <= w_drop_sum[DROP_W-1:0];
    end
  end

  timestamp_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk125 (clk125),
    .rst    (rst),
    .push   (w_push),
    .pop    (w_pop),
    .din    (w_din),
    .dout   (w_dout),
    .empty  (w_empty),
    .full   (w_full),
    .level  (fifo_level)
  );

  // Record fields are forced to zero while nothing is queued
  assign out_valid = ~w_empty;
  assign out_ch    = w_empty ? '0 : w_dout.ch;
  assign out_seq   = w_empty ? '0 : w_dout.seq;
  assign out_t     = w_empty ? '0 : w_dout.t;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_timestamp_capture.sv
// Bench for timestamp_capture: queue-level reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_timestamp_capture;

  localparam int N_CH       = 2;
  localparam int MIN_PULSE  = 4;
  localparam int FIFO_DEPTH = 8;

  logic              clk125 = 1'b0;
  logic              rst;
  logic [63:0]       t;
  logic [N_CH-1:0]   trig;
  logic [N_CH-1:0]   trig_en;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_ch;
  logic [15:0]       out_seq;
  logic [63:0]       out_t;
  logic [15:0]       drop_cnt;
  logic [$clog2(FIFO_DEPTH):0] fifo_level;

  timestamp_capture #(
    .N_CH       (N_CH),
    .MIN_PULSE  (MIN_PULSE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk125     (clk125),
    .rst        (rst),
    .t          (t),
    .trig       (trig),
    .trig_en    (trig_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ch     (out_ch),
    .out_seq    (out_seq),
    .out_t      (out_t),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #4 clk125 = ~clk125;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // literal expectations posted by the stimulus, checked by the compare process
  string       lit_name [64];
  logic [63:0] lit_act  [64];
  logic [63:0] lit_exp  [64];
  int          lit_wr = 0;
  int          lit_rd = 0;

  // captured transfers
  logic [2:0]  cap_ch  [16];
  logic [15:0] cap_seq [16];
  logic [63:0] cap_t   [16];
  int          cap_cyc [16];
  int          nrec;

  // reference model
  typedef struct {
    int          ch;
    logic [15:0] seq;
    logic [63:0] ts;
  } mrec_t;

  mrec_t           mq[$];
  logic [N_CH-1:0] m_s1, m_s, m_ps, m_pend, m_qual, m_pend_nx;
  int              m_cnt [N_CH];
  logic [63:0]     m_st  [N_CH];
  logic [63:0]     m_pt  [N_CH];
  logic [15:0]     m_seq;
  logic [15:0]     m_drop;
  logic            m_known = 1'b0;
  int              m_win;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    lit_name[lit_wr] = name;
    lit_act[lit_wr]  = act;
    lit_exp[lit_wr]  = exp;
    lit_wr++;
  endtask

  task automatic model_reset();
    mq.delete();
    m_s1 = '0; m_s = '0; m_ps = '0; m_pend = '0;
    m_seq = '0; m_drop = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c] = 0; m_st[c] = '0; m_pt[c] = '0;
    end
  endtask

  // One cycle of the rules: run-length filter, pop, priority push, drops, enables
  task automatic model_step();
    m_qual = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (!trig_en[c])              m_cnt[c] = 0;
      else if (m_s[c] && !m_ps[c]) begin m_cnt[c] = 1; m_st[c] = t; end
      else if (m_s[c] && m_cnt[c] > 0) m_cnt[c]++;
      else                          m_cnt[c] = 0;
      if (trig_en[c] && m_s[c] && m_cnt[c] == MIN_PULSE) begin
        m_qual[c] = 1'b1;
        m_cnt[c]  = 0;
      end
    end
    m_pend_nx = m_pend;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    m_win = -1;
    for (int c = N_CH - 1; c >= 0; c--) if (m_pend[c]) m_win = c;
    if (m_win >= 0 && mq.size() < FIFO_DEPTH) begin
      mq.push_back('{ch: m_win, seq: m_seq, ts: m_pt[m_win]});
      m_seq = m_seq + 16'd1;
      m_pend_nx[m_win] = 1'b0;
    end
    for (int c = 0; c < N_CH; c++) begin
      if (m_qual[c]) begin
        if (m_pend[c]) begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
        end else begin
          m_pend_nx[c] = 1'b1;
          m_pt[c]      = m_st[c];
        end
      end
      if (!trig_en[c]) m_pend_nx[c] = 1'b0;
    end
    m_pend = m_pend_nx;
  endtask

  // Compare process: mid-cycle, check DUT against the model, then advance it
  initial begin
    forever begin
      @(negedge clk125);
      while (lit_rd < lit_wr) begin
        check(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
        lit_rd++;
      end
      if (m_known) begin
        check("valid", 64'(out_valid), 64'(mq.size() > 0));
        check("level", 64'(fifo_level), 64'(mq.size()));
        check("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        if (mq.size() > 0) begin
          check("out_ch", 64'(out_ch), 64'(mq[0].ch));
          check("out_seq", 64'(out_seq), 64'(mq[0].seq));
          check("out_t", out_t, mq[0].ts);
        end else begin
          check("idle_ch", 64'(out_ch), 64'd0);
          check("idle_seq", 64'(out_seq), 64'd0);
          check("idle_t", out_t, 64'd0);
        end
      end
      if (rst) begin
        model_reset();
        m_known = 1'b1;
      end else if (m_known) begin
        model_step();
        m_ps = m_s;
        m_s  = m_s1;
        m_s1 = trig;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk125);
      #1;
      cyc++;
      t = 64'd1000 + 64'(cyc);
    end
  endtask

  // Tick n cycles, optionally change trig at tick rel_i, record every transfer
  task automatic watch(input int n, input int rel_i, input logic [N_CH-1:0] rel_val);
    nrec = 0;
    for (int i = 1; i <= n; i++) begin
      tick(1);
      if (i == rel_i) trig = rel_val;
      if (out_valid && out_ready && nrec < 16) begin
        cap_ch[nrec]  = out_ch;
        cap_seq[nrec] = out_seq;
        cap_t[nrec]   = out_t;
        cap_cyc[nrec] = cyc;
        nrec++;
      end
    end
  endtask

  task automatic pulse_train(input int n_ev);
    for (int e = 0; e < n_ev; e++) begin
      trig[e % 2] = 1'b1;
      tick(6);
      trig[e % 2] = 1'b0;
      tick(4);
    end
  endtask

  int k;

  initial begin
    rst = 1'b1; trig = '0; trig_en = '1; out_ready = 1'b1; t = 64'd1000;
    tick(3);
    lit("rst_valid", 64'(out_valid), 64'd0);
    lit("rst_level", 64'(fifo_level), 64'd0);
    lit("rst_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick(4);

    // 1: single long pulse on ch0
    k = cyc;
    trig[0] = 1'b1;
    watch(14, 10, '0);
    lit("t1_count", 64'(nrec), 64'd1);
    lit("t1_latency", 64'(cap_cyc[0] - k), 64'd7);
    lit("t1_t", cap_t[0], 64'd1000 + 64'(k) + 64'd2);
    lit("t1_ch", 64'(cap_ch[0]), 64'd0);
    lit("t1_seq", 64'(cap_seq[0]), 64'd0);

    // 2: short glitch on ch1 is filtered silently
    tick(4);
    trig[1] = 1'b1;
    watch(14, 3, '0);
    lit("t2_count", 64'(nrec), 64'd0);
    lit("t2_drop", 64'(drop_cnt), 64'd0);

    // 3: simultaneous edges, ch0 first then ch1
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    k = cyc;
    trig = 2'b11;
    watch(16, 8, '0);
    lit("t3_count", 64'(nrec), 64'd2);
    lit("t3_ch0", 64'(cap_ch[0]), 64'd0);
    lit("t3_seq0", 64'(cap_seq[0]), 64'd0);
    lit("t3_lat0", 64'(cap_cyc[0] - k), 64'd7);
    lit("t3_ch1", 64'(cap_ch[1]), 64'd1);
    lit("t3_seq1", 64'(cap_seq[1]), 64'd1);
    lit("t3_lat1", 64'(cap_cyc[1] - k), 64'd8);
    lit("t3_t0", cap_t[0], 64'd1000 + 64'(k) + 64'd2);
    lit("t3_t1", cap_t[1], 64'd1000 + 64'(k) + 64'd2);

    // 4: reader stalled, 12 alternating events: 8 stored, 2 pending, 2 dropped
    rst = 1'b1; tick(2); rst = 1'b0; tick(2);
    out_ready = 1'b0;
    pulse_train(12);
    tick(8);
    lit("t4_level", 64'(fifo_level), 64'd8);
    lit("t4_drop", 64'(drop_cnt), 64'd2);
    lit("t4_valid", 64'(out_valid), 64'd1);
    lit("t4_head_seq", 64'(out_seq), 64'd0);
    lit("t4_head_ch", 64'(out_ch), 64'd0);

    // 5: push and pop on a full FIFO keep the level at 8, then drain
    out_ready = 1'b1;
    nrec = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid && nrec < 16) begin
        cap_ch[nrec]  = out_ch;
        cap_seq[nrec] = out_seq;
        nrec++;
      end
      tick(1);
      if (i == 0) lit("t5_level_a", 64'(fifo_level), 64'd8);
      if (i == 1) lit("t5_level_b", 64'(fifo_level), 64'd8);
    end
    lit("t5_count", 64'(nrec), 64'd10);
    lit("t5_drop", 64'(drop_cnt), 64'd2);
    for (int j = 0; j < 10; j++) begin
      lit("t5_seq", 64'(cap_seq[j]), 64'(j));
      lit("t5_ch", 64'(cap_ch[j]), 64'(j % 2));
    end

    // 6: reset with 5 records queued
    out_ready = 1'b0;
    pulse_train(5);
    tick(8);
    lit("t6_level_pre", 64'(fifo_level), 64'd5);
    lit("t6_drop_pre", 64'(drop_cnt), 64'd2);
    rst = 1'b1;
    tick(1);
    lit("t6_valid", 64'(out_valid), 64'd0);
    lit("t6_level", 64'(fifo_level), 64'd0);
    lit("t6_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(2);
    trig[1] = 1'b1;
    watch(14, 8, '0);
    lit("t6_count", 64'(nrec), 64'd1);
    lit("t6_ch", 64'(cap_ch[0]), 64'd1);
    lit("t6_seq", 64'(cap_seq[0]), 64'd0);

    // 7: re-enable with pin already high does not fire; next 0->1 does
    tick(4);
    trig_en[0] = 1'b0;
    trig[0] = 1'b1;
    tick(6);
    trig_en[0] = 1'b1;
    watch(12, -1, '0);
    lit("t7_none", 64'(nrec), 64'd0);
    trig[0] = 1'b0;
    tick(4);
    trig[0] = 1'b1;
    watch(14, 8, '0);
    lit("t7_count", 64'(nrec), 64'd1);
    lit("t7_ch", 64'(cap_ch[0]), 64'd0);
    lit("t7_seq", 64'(cap_seq[0]), 64'd1);

    tick(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
